// File: rtl/rob_pkg.sv
// Shared reorder-buffer parameters and the entry record.
package rob_pkg;
  localparam int ROB_DEPTH  = 32;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int PTR_W      = ROB_IDX_W + 1;
  localparam int CDB_WIDTH  = 2;
  localparam int PRF_IDX_W  = 6;
  localparam int ARCH_IDX_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [PRF_IDX_W-1:0]  rd_phy;
    logic [ARCH_IDX_W-1:0] rd_arch;
  } rob_entry_t;

  // Same slot, opposite lap: the buffer holds ROB_DEPTH entries.
  function automatic logic ptr_full(input logic [PTR_W-1:0] h, input logic [PTR_W-1:0] t);
    return (h[ROB_IDX_W-1:0] == t[ROB_IDX_W-1:0]) && (h[ROB_IDX_W] != t[ROB_IDX_W]);
  endfunction
endpackage

// File: rtl/rob_ptr.sv
// Wrap-tagged ring pointer: low bits index the ring, MSB toggles each lap.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;
  assign ptr_o = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rob.sv
// In-order reorder buffer: allocate at dispatch, mark done from the CDB, retire one per cycle.
// Optional ROB_PERF_CNT_EN adds commit and dispatch-stall counters.
module rob
  import rob_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  dispatch_valid,
  output logic                                  dispatch_ready,
  input  logic [PRF_IDX_W-1:0]                  dispatch_rd_phy,
  input  logic [ARCH_IDX_W-1:0]                 dispatch_rd_arch,
  output logic [ROB_IDX_W-1:0]                  dispatch_rob_id,
  input  logic [CDB_WIDTH-1:0]                  cdb_valid,
  input  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]   cdb_rob_id,
  output logic                                  commit_valid,
  output logic [ROB_IDX_W-1:0]                  commit_rob_id,
  output logic [PRF_IDX_W-1:0]                  commit_rd_phy,
  output logic [ARCH_IDX_W-1:0]                 commit_rd_arch
`ifdef ROB_PERF_CNT_EN
  ,output logic [31:0]                          perf_commit_cnt
  ,output logic [31:0]                          perf_full_cnt
`endif
);
  rob_entry_t             entries_q [ROB_DEPTH];
  rob_entry_t             entries_d [ROB_DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [ROB_IDX_W-1:0]   head_idx, tail_idx;
  logic                   dispatch_fire;

  rob_ptr #(.W(PTR_W)) u_head (.clk(clk), .rst_n(rst), .inc_i(commit_valid),  .ptr_o(head));
  rob_ptr #(.W(PTR_W)) u_tail (.clk(clk), .rst_n(rst), .inc_i(dispatch_fire), .ptr_o(tail));

  assign head_idx        = head[ROB_IDX_W-1:0];
  assign tail_idx        = tail[ROB_IDX_W-1:0];
  assign dispatch_ready  = !ptr_full(head, tail);
  assign dispatch_fire   = dispatch_valid && dispatch_ready;
  assign dispatch_rob_id = tail_idx;

  assign commit_valid    = entries_q[head_idx].valid && entries_q[head_idx].done;
  assign commit_rob_id   = head_idx;
  assign commit_rd_phy   = entries_q[head_idx].rd_phy;
  assign commit_rd_arch  = entries_q[head_idx].rd_arch;

  // Retire clear is applied after CDB marking so a late CDB hit on the
  // retiring head cannot resurrect its done bit.
  always_comb begin
    entries_d = entries_q;
    for (int p = 0; p < CDB_WIDTH; p++) begin
      if (cdb_valid[p] && entries_q[cdb_rob_id[p]].valid)
        entries_d[cdb_rob_id[p]].done = 1'b1;
    end
    if (commit_valid) begin
      entries_d[head_idx].valid = 1'b0;
      entries_d[head_idx].done  = 1'b0;
    end
    if (dispatch_fire) begin
      entries_d[tail_idx].valid   = 1'b1;
      entries_d[tail_idx].done    = 1'b0;
      entries_d[tail_idx].rd_phy  = dispatch_rd_phy;
      entries_d[tail_idx].rd_arch = dispatch_rd_arch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commit_q <= '0;
      perf_full_q   <= '0;
    end else begin
      if (commit_valid)                     perf_commit_q <= perf_commit_q + 32'd1;
      if (dispatch_valid && !dispatch_ready) perf_full_q   <= perf_full_q + 32'd1;
    end
  end

  assign perf_commit_cnt = perf_commit_q;
  assign perf_full_cnt   = perf_full_q;
`endif
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: vector table plus hand sequences for full/wrap, streaming and reset.
module tb_rob;
  import rob_pkg::*;

  logic                                clk, rst;
  logic                                dispatch_valid, dispatch_ready;
  logic [PRF_IDX_W-1:0]                dispatch_rd_phy;
  logic [ARCH_IDX_W-1:0]               dispatch_rd_arch;
  logic [ROB_IDX_W-1:0]                dispatch_rob_id;
  logic [CDB_WIDTH-1:0]                cdb_valid;
  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0] cdb_rob_id;
  logic                                commit_valid;
  logic [ROB_IDX_W-1:0]                commit_rob_id;
  logic [PRF_IDX_W-1:0]                commit_rd_phy;
  logic [ARCH_IDX_W-1:0]               commit_rd_arch;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                         perf_commit_cnt, perf_full_cnt;
`endif

  rob dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rd_phy(dispatch_rd_phy), .dispatch_rd_arch(dispatch_rd_arch),
    .dispatch_rob_id(dispatch_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_rd_phy(commit_rd_phy), .commit_rd_arch(commit_rd_arch)
`ifdef ROB_PERF_CNT_EN
    ,.perf_commit_cnt(perf_commit_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst_n, dv, phy, arch, cv, id0, id1;
    int e_rdy, e_id, e_cv, e_cid, e_phy, e_arch;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(int rst_n, int dv, int phy, int arch, int cv, int id0, int id1,
                              int e_rdy, int e_id, int e_cv, int e_cid, int e_phy, int e_arch);
    vec_t v;
    v.rst_n = rst_n; v.dv = dv; v.phy = phy; v.arch = arch; v.cv = cv; v.id0 = id0; v.id1 = id1;
    v.e_rdy = e_rdy; v.e_id = e_id; v.e_cv = e_cv; v.e_cid = e_cid; v.e_phy = e_phy; v.e_arch = e_arch;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_out(input string tag, input int rdy, input int id, input int cv,
                           input int cid, input int phy, input int arch);
    chk({tag, ".ready"}, int'(dispatch_ready), rdy);
    chk({tag, ".rob_id"}, int'(dispatch_rob_id), id);
    chk({tag, ".commit_valid"}, int'(commit_valid), cv);
    if (cv != 0) begin
      chk({tag, ".commit_id"}, int'(commit_rob_id), cid);
      chk({tag, ".commit_phy"}, int'(commit_rd_phy), phy);
      chk({tag, ".commit_arch"}, int'(commit_rd_arch), arch);
    end
  endtask

  task automatic idle_in();
    dispatch_valid = 1'b0; dispatch_rd_phy = '0; dispatch_rd_arch = '0;
    cdb_valid = '0; cdb_rob_id = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_in(); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #1;
    check_out("reset", 1, 0, 0, 0, 0, 0);

    // rst dv phy arch cdbv id0 id1 | rdy id cv cid phy arch
    vecs.push_back(mk(1,1, 1,1, 0,0,0, 1,0,0,0,0,0));   // single uop
    vecs.push_back(mk(1,0, 0,0, 1,0,0, 1,1,0,0,0,0));   // CDB id0, no bypass
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,1,1,0,1,1));   // commits next cycle
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,1,0,0,0,0));   // empty again
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 1,0,0,0,0,0));   // async reset row
    vecs.push_back(mk(1,1,10,2, 0,0,0, 1,0,0,0,0,0));   // ids 0..3
    vecs.push_back(mk(1,1,11,3, 0,0,0, 1,1,0,0,0,0));
    vecs.push_back(mk(1,1,12,4, 0,0,0, 1,2,0,0,0,0));
    vecs.push_back(mk(1,1,13,5, 0,0,0, 1,3,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0, 1,3,0, 1,4,0,0,0,0));   // complete 3 on port 0
    vecs.push_back(mk(1,0, 0,0, 2,0,1, 1,4,0,0,0,0));   // complete 1 on port 1
    vecs.push_back(mk(1,0, 0,0, 1,2,0, 1,4,0,0,0,0));   // complete 2 on port 0
    vecs.push_back(mk(1,0, 0,0, 2,0,0, 1,4,0,0,0,0));   // complete 0 on port 1
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,4,1,0,10,2));  // in-order retirement
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,4,1,1,11,3));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,4,1,2,12,4));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,4,1,3,13,5));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,4,0,0,0,0));
    vecs.push_back(mk(1,1,20,6, 0,0,0, 1,4,0,0,0,0));   // ids 4,5
    vecs.push_back(mk(1,1,21,7, 0,0,0, 1,5,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0, 3,5,5, 1,6,0,0,0,0));   // both ports id5
    vecs.push_back(mk(1,0, 0,0, 1,20,0,1,6,0,0,0,0));   // unallocated id20
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,6,0,0,0,0));   // head 4 not done
    vecs.push_back(mk(1,0, 0,0, 1,4,0, 1,6,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,6,1,4,20,6));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,6,1,5,21,7));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,6,0,0,0,0));   // id20 never retires
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 1,6,0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst              = vecs[i].rst_n[0];
      dispatch_valid   = vecs[i].dv[0];
      dispatch_rd_phy  = PRF_IDX_W'(vecs[i].phy);
      dispatch_rd_arch = ARCH_IDX_W'(vecs[i].arch);
      cdb_valid        = CDB_WIDTH'(vecs[i].cv);
      cdb_rob_id[0]    = ROB_IDX_W'(vecs[i].id0);
      cdb_rob_id[1]    = ROB_IDX_W'(vecs[i].id1);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_id, vecs[i].e_cv,
                vecs[i].e_cid, vecs[i].e_phy, vecs[i].e_arch);
    end

    // Fill to 32, retire id 0, confirm ready lags the commit and id 0 is reused.
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      @(negedge clk);
      idle_in(); dispatch_valid = 1'b1;
      dispatch_rd_phy = PRF_IDX_W'(i); dispatch_rd_arch = ARCH_IDX_W'(i);
      #1;
      chk($sformatf("fill%0d.ready", i), int'(dispatch_ready), 1);
      chk($sformatf("fill%0d.rob_id", i), int'(dispatch_rob_id), i);
    end
    @(negedge clk);
    dispatch_rd_phy = 6'd63;
    #1;
    chk("full.ready", int'(dispatch_ready), 0);
    chk("full.commit_valid", int'(commit_valid), 0);
    @(negedge clk);
    idle_in(); cdb_valid = 2'b01; cdb_rob_id[0] = '0;
    #1;
    chk("full_cdb.ready", int'(dispatch_ready), 0);
    @(negedge clk);
    idle_in(); dispatch_valid = 1'b1; dispatch_rd_phy = 6'd40; dispatch_rd_arch = 5'd9;
    #1;
    chk("full_commit.commit_valid", int'(commit_valid), 1);
    chk("full_commit.commit_id", int'(commit_rob_id), 0);
    chk("full_commit.commit_phy", int'(commit_rd_phy), 0);
    chk("full_commit.ready", int'(dispatch_ready), 0);
    @(negedge clk);
    dispatch_rd_phy = 6'd41; dispatch_rd_arch = 5'd10;
    #1;
    chk("wrap.ready", int'(dispatch_ready), 1);
    chk("wrap.rob_id", int'(dispatch_rob_id), 0);
    chk("wrap.commit_valid", int'(commit_valid), 0);
    @(negedge clk);
    idle_in();
    #1;
    chk("wrap_full.ready", int'(dispatch_ready), 0);
    chk("wrap_full.rob_id", int'(dispatch_rob_id), 1);

    // Steady stream: dispatch k, complete k-2, retire k-3 every cycle.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      idle_in(); dispatch_valid = 1'b1;
      dispatch_rd_phy = PRF_IDX_W'(k); dispatch_rd_arch = ARCH_IDX_W'(k);
      if (k >= 2) begin cdb_valid = 2'b01; cdb_rob_id[0] = ROB_IDX_W'(k - 2); end
      #1;
      check_out($sformatf("stream%0d", k), 1, k % 32, (k >= 3) ? 1 : 0,
                (k + 29) % 32, (k + 61) % 64, (k + 29) % 32);
    end

    // Mid-run reset with five entries in flight and the head committable.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_in(); dispatch_valid = 1'b1;
      dispatch_rd_phy = PRF_IDX_W'(50 + i); dispatch_rd_arch = ARCH_IDX_W'(i);
      if (i == 4) begin cdb_valid = 2'b01; cdb_rob_id[0] = '0; end
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("pre_rst.commit_valid", int'(commit_valid), 1);
    chk("pre_rst.rob_id", int'(dispatch_rob_id), 5);
    #1 rst = 1'b0;
    #1;
    check_out("mid_rst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("post_rst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_out("post_rst2", 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
